// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default line settings and the
// oversampling divider calculation used by both the receive and transmit sides.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

  localparam int unsigned DefaultClkFreq = 100_000_000;
  localparam int unsigned DefaultBaud    = 9600;
  localparam int unsigned DefaultOvs     = 16;

  // Rounded clocks-per-tick; never returns 0 so the divider always advances.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned ovs);
    int unsigned den;
    int unsigned div;
    den = baud * ovs;
    if (den == 0) begin
      return 1;
    end
    div = (clk_freq + den / 2) / den;
    return (div == 0) ? 1 : div;
  endfunction

  // Counter width able to hold 0..n-1, at least one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/baud_tick.sv
// Free-running divider emitting a one-clock tick every Div clocks. A restart
// realigns the phase so the first tick lands exactly Div clocks later.
module baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned Div = 651
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CntW = cnt_width(Div);
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q;

  // Count 0..Div-1, wrapping; restart forces phase back to 0.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt_q <= '0;
    end else if (cnt_q == CntMax) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Decoded from the counter register; only consumed internally by the FSM.
  assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/uart_rx_core.sv
// 16x oversampling UART receiver with start/stop validation, a valid/ready
// holding register, receive and framing-error strobes and a sticky overrun flag.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DefaultClkFreq,
  parameter int unsigned BAUD     = DefaultBaud,
  parameter int unsigned OVS      = DefaultOvs
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  input  logic       ready,
  output logic       received,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned Div   = calc_div(CLK_FREQ, BAUD, OVS);
  localparam int unsigned TickW = cnt_width(OVS);
  // Start bit is checked at its middle; data and stop bits one full bit later.
  localparam logic [TickW-1:0] MidTick  = TickW'(OVS / 2 - 1);
  localparam logic [TickW-1:0] LastTick = TickW'(OVS - 1);

  logic             rx_meta;
  logic             rxs;
  logic             rxs_q;
  logic [1:0]       prime_q;
  logic             fall;
  logic             restart;
  logic             tick;

  rx_state_e        state_q;
  logic [TickW-1:0] tick_cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;

  // Two-flop synchronizer plus one history flop for edge detection.
  // prime_q holds off edge detection until the chain carries real line samples
  // after reset, so a line that is still low at release is not seen as a start.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_q   <= 1'b1;
      prime_q <= 2'd0;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_q   <= rxs;
      if (prime_q != 2'd3) begin
        prime_q <= prime_q + 2'd1;
      end
    end
  end

  // High-to-low transition on the synchronized line.
  assign fall    = (prime_q == 2'd3) && rxs_q && !rxs;
  assign restart = (state_q == StIdle) && fall;

  baud_tick #(
    .Div(Div)
  ) u_baud_tick (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  // Frame FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_out   <= '0;
      valid      <= 1'b0;
      received   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      received  <= 1'b0;
      frame_err <= 1'b0;
      // Consume first; a load later in this block overrides it.
      if (valid && ready) begin
        valid <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (fall) begin
            state_q    <= StStart;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            busy       <= 1'b1;
          end
        end

        StStart: begin
          if (tick) begin
            if (tick_cnt_q == MidTick) begin
              tick_cnt_q <= '0;
              if (rxs) begin
                // Line back high at mid start bit: treat as a glitch.
                state_q <= StIdle;
                busy    <= 1'b0;
              end else begin
                state_q <= StData;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end

        StData: begin
          if (tick) begin
            if (tick_cnt_q == LastTick) begin
              tick_cnt_q <= '0;
              // LSB arrives first, so shift in from the top.
              shift_q    <= {rxs, shift_q[7:1]};
              bit_cnt_q  <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                state_q <= StStop;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end

        StStop: begin
          if (tick) begin
            if (tick_cnt_q == LastTick) begin
              // Leave at mid stop bit so the next start edge is caught early.
              tick_cnt_q <= '0;
              state_q    <= StIdle;
              busy       <= 1'b0;
              if (rxs) begin
                data_out <= shift_q;
                received <= 1'b1;
                valid    <= 1'b1;
                if (valid && !ready) begin
                  overrun <= 1'b1;
                end
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end

        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at a reduced line rate (Div = 10, 160 clocks
// per bit) so each frame is short; expected values are hand-computed constants.
module tb_uart_rx_core;

  localparam int unsigned ClkFreq = 1_600_000;
  localparam int unsigned Baud    = 10_000;
  localparam int unsigned Ovs     = 16;
  localparam int          BitClks = 160;
  // 2 sync + 1 edge + 8*Div + 9*16*Div = 3 + 80 + 1440
  localparam int          ExpLatency = 1523;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       ready;
  logic [7:0] data_out;
  logic       valid;
  logic       received;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int rcv_cnt  = 0;
  int ferr_cnt = 0;
  int vld_cnt  = 0;
  int rcv_base;
  int ferr_base;
  int vld_base;
  int lat;

  always #5 clk = ~clk;

  uart_rx_core #(
    .CLK_FREQ(ClkFreq),
    .BAUD    (Baud),
    .OVS     (Ovs)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .data_out (data_out),
    .valid    (valid),
    .ready    (ready),
    .received (received),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  // Strobe and valid-cycle counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (received) rcv_cnt++;
    if (frame_err) ferr_cnt++;
    if (valid) vld_cnt++;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Assumes the caller is 1 time unit after a rising edge; returns likewise.
  task automatic drive_level(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop, input int bclk);
    drive_level(1'b0, bclk);
    for (int i = 0; i < 8; i++) begin
      drive_level(d[i], bclk);
    end
    drive_level(stop, bclk);
    rx = 1'b1;
  endtask

  task automatic mark();
    rcv_base  = rcv_cnt;
    ferr_base = ferr_cnt;
    vld_base  = vld_cnt;
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    drive_level(1'b1, 20);

    // Reset state
    check_eq("rst_data_out", data_out, 8'h00);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_no_strobes", rcv_cnt + ferr_cnt, 0);

    // 0x41 with ready held high, plus latency from the falling edge
    ready = 1'b1;
    mark();
    fork
      send_byte(8'h41, 1'b1, BitClks);
      begin
        lat = 0;
        do begin
          @(posedge clk);
          lat++;
          @(negedge clk);
        end while (!received && lat < 3000);
      end
    join
    drive_level(1'b1, 40);
    check_eq("t41_latency", (lat >= ExpLatency - 1 && lat <= ExpLatency + 1) ? ExpLatency : lat,
             ExpLatency);
    check_eq("t41_received", rcv_cnt - rcv_base, 1);
    check_eq("t41_data", data_out, 8'h41);
    check_eq("t41_valid_cycles", vld_cnt - vld_base, 1);
    check_eq("t41_frame_err", ferr_cnt - ferr_base, 0);
    check_eq("t41_busy", busy, 0);

    // 0x55 then 0xAA back-to-back with nobody consuming
    ready = 1'b0;
    mark();
    send_byte(8'h55, 1'b1, BitClks);
    check_eq("t55_data", data_out, 8'h55);
    check_eq("t55_valid", valid, 1);
    check_eq("t55_overrun", overrun, 0);
    send_byte(8'hAA, 1'b1, BitClks);
    drive_level(1'b1, 40);
    check_eq("tAA_data", data_out, 8'hAA);
    check_eq("tAA_valid", valid, 1);
    check_eq("tAA_overrun", overrun, 1);
    check_eq("tAA_received", rcv_cnt - rcv_base, 2);

    // 0x3C with a low stop bit while 0xAA is still pending
    mark();
    send_byte(8'h3C, 1'b0, BitClks);
    drive_level(1'b1, 40);
    check_eq("t3C_frame_err", ferr_cnt - ferr_base, 1);
    check_eq("t3C_received", rcv_cnt - rcv_base, 0);
    check_eq("t3C_data_kept", data_out, 8'hAA);
    check_eq("t3C_valid_kept", valid, 1);

    // Consume; overrun stays sticky
    ready = 1'b1;
    drive_level(1'b1, 1);
    check_eq("consume_valid", valid, 0);
    check_eq("consume_overrun", overrun, 1);

    // Short glitch (< 8*Div) followed by a real 0x7E
    mark();
    drive_level(1'b0, 40);
    drive_level(1'b1, 120);
    check_eq("glitch_busy", busy, 0);
    check_eq("glitch_strobes", (rcv_cnt - rcv_base) + (ferr_cnt - ferr_base), 0);
    send_byte(8'h7E, 1'b1, BitClks);
    drive_level(1'b1, 40);
    check_eq("t7E_received", rcv_cnt - rcv_base, 1);
    check_eq("t7E_data", data_out, 8'h7E);
    check_eq("t7E_frame_err", ferr_cnt - ferr_base, 0);

    // Break: line held low for 12 bit times
    mark();
    drive_level(1'b0, 12 * BitClks);
    check_eq("break_busy_low", busy, 0);
    drive_level(1'b1, 40);
    check_eq("break_frame_err", ferr_cnt - ferr_base, 1);
    check_eq("break_received", rcv_cnt - rcv_base, 0);
    check_eq("break_data_kept", data_out, 8'h7E);

    // Reset during bit 4 of 0x0F, then a clean 0xC3
    ready = 1'b0;
    mark();
    fork
      send_byte(8'h0F, 1'b1, BitClks);
      begin
        repeat (5 * BitClks + BitClks / 2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
      end
    join
    drive_level(1'b1, 40);
    check_eq("abort_strobes", (rcv_cnt - rcv_base) + (ferr_cnt - ferr_base), 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_data_cleared", data_out, 8'h00);
    send_byte(8'hC3, 1'b1, BitClks);
    drive_level(1'b1, 40);
    check_eq("tC3_data", data_out, 8'hC3);
    check_eq("tC3_valid", valid, 1);
    check_eq("tC3_overrun", overrun, 0);
    check_eq("tC3_received", rcv_cnt - rcv_base, 1);
    check_eq("tC3_frame_err", ferr_cnt - ferr_base, 0);
    check_eq("tC3_busy", busy, 0);

    // 0x99 with the sender 3% fast, then 3% slow
    ready = 1'b1;
    mark();
    send_byte(8'h99, 1'b1, 155);
    drive_level(1'b1, 40);
    check_eq("t99_fast_data", data_out, 8'h99);
    check_eq("t99_fast_received", rcv_cnt - rcv_base, 1);
    drive_level(1'b1, 1);
    check_eq("t99_fast_consumed", valid, 0);
    send_byte(8'h99, 1'b1, 165);
    drive_level(1'b1, 40);
    check_eq("t99_slow_data", data_out, 8'h99);
    check_eq("t99_slow_received", rcv_cnt - rcv_base, 2);
    check_eq("t99_frame_err", ferr_cnt - ferr_base, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
